proc_control_unit: RTL and testbench

//   Instruction sequencer for the simple bus-based processor. Latches a 9-bit

---
 rtl/proc_control_unit.sv | 160 ++++++++++++++++
 tb/tb_proc_control_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_control_unit.sv
// proc_control_unit: instruction sequencer for the bus-based processor.
// Latches a 9-bit instruction (op, X, Y) from DIN and steps it through
// timesteps T0..T3, driving the shared bus mux select and register load enables.
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   run      : start request, sampled only in T0
//   ir_in    : instruction word (DIN), captured in T0 when run=1
//   ir_ld    : IR load strobe (T0 & run)
//   bus_sel  : bus mux channel (0..NREG-1 = Rx, NREG = DIN, NREG+1 = G)
//   r_en     : one-hot general register load enables
//   a_en     : A register load
//   g_en     : G register load
//   add_sub  : ALU op for the G load, 0 = add, 1 = sub
//   done     : one-cycle instruction-complete pulse
module proc_control_unit #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned NREG   = 2**REG_AW,
  parameter int unsigned IR_W   = 3 + 2*REG_AW,
  parameter int unsigned SEL_W  = $clog2(NREG+2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [IR_W-1:0]  ir_in,
  output logic             ir_ld,
  output logic [SEL_W-1:0] bus_sel,
  output logic [NREG-1:0]  r_en,
  output logic             a_en,
  output logic             g_en,
  output logic             add_sub,
  output logic             done
);

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [SEL_W-1:0] SEL_DIN = SEL_W'(NREG);
  localparam logic [SEL_W-1:0] SEL_G   = SEL_W'(NREG + 1);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [IR_W-1:0]   ir_q;

  logic [2:0]        op;
  logic [REG_AW-1:0] rx;
  logic [REG_AW-1:0] ry;
  logic [NREG-1:0]   rx_onehot;
  logic              is_alu;

  logic              ir_ld_c;
  logic [SEL_W-1:0]  bus_sel_c;
  logic [NREG-1:0]   r_en_c;
  logic              a_en_c;
  logic              g_en_c;
  logic              add_sub_c;
  logic              done_c;

  // Instruction field decode
  assign op        = ir_q[IR_W-1 -: 3];
  assign rx        = ir_q[2*REG_AW-1 -: REG_AW];
  assign ry        = ir_q[REG_AW-1:0];
  assign rx_onehot = NREG'(1) << rx;
  assign is_alu    = (op == OP_ADD) || (op == OP_SUB);

  // State and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == T0) && run) begin
        ir_q <= ir_in;
      end
    end
  end

  // Next-state and timestep decode
  always_comb begin
    state_d   = state_q;
    ir_ld_c   = 1'b0;
    bus_sel_c = '0;
    r_en_c    = '0;
    a_en_c    = 1'b0;
    g_en_c    = 1'b0;
    add_sub_c = 1'b0;
    done_c    = 1'b0;

    unique case (state_q)
      T0: begin
        ir_ld_c = run;
        state_d = run ? T1 : T0;
      end
      T1: begin
        state_d = T0;
        unique case (op)
          OP_MV: begin
            bus_sel_c = SEL_W'(ry);
            r_en_c    = rx_onehot;
            done_c    = 1'b1;
          end
          OP_MVI: begin
            bus_sel_c = SEL_DIN;
            r_en_c    = rx_onehot;
            done_c    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus_sel_c = SEL_W'(rx);
            a_en_c    = 1'b1;
            state_d   = T2;
          end
          default: begin
            done_c = 1'b1;
          end
        endcase
      end
      T2: begin
        state_d = T0;
        if (is_alu) begin
          bus_sel_c = SEL_W'(ry);
          g_en_c    = 1'b1;
          add_sub_c = (op == OP_SUB);
          state_d   = T3;
        end
      end
      T3: begin
        state_d = T0;
        if (is_alu) begin
          bus_sel_c = SEL_G;
          r_en_c    = rx_onehot;
          done_c    = 1'b1;
        end
      end
      default: begin
        state_d = T0;
      end
    endcase
  end

  // Force every output low while reset is asserted, independent of run
  assign ir_ld   = rst_n & ir_ld_c;
  assign bus_sel = rst_n ? bus_sel_c : '0;
  assign r_en    = rst_n ? r_en_c : '0;
  assign a_en    = rst_n & a_en_c;
  assign g_en    = rst_n & g_en_c;
  assign add_sub = rst_n & add_sub_c;
  assign done    = rst_n & done_c;

endmodule

// File: tb/tb_proc_control_unit.sv
// Self-checking bench for proc_control_unit. Outputs are packed as
// {ir_ld, bus_sel[3:0], r_en[7:0], a_en, g_en, add_sub, done}.
module tb_proc_control_unit;

  localparam int unsigned REG_AW = 3;
  localparam int unsigned NREG   = 8;
  localparam int unsigned IR_W   = 9;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned OV_W   = 1 + SEL_W + NREG + 4;

  logic             clk;
  logic             rst_n;
  logic             run;
  logic [IR_W-1:0]  ir_in;
  logic             ir_ld;
  logic [SEL_W-1:0] bus_sel;
  logic [NREG-1:0]  r_en;
  logic             a_en;
  logic             g_en;
  logic             add_sub;
  logic             done;

  int n_cmp;
  int n_bad;

  proc_control_unit #(
    .REG_AW(REG_AW),
    .NREG  (NREG),
    .IR_W  (IR_W),
    .SEL_W (SEL_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .ir_in  (ir_in),
    .ir_ld  (ir_ld),
    .bus_sel(bus_sel),
    .r_en   (r_en),
    .a_en   (a_en),
    .g_en   (g_en),
    .add_sub(add_sub),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [OV_W-1:0] obs();
    return {ir_ld, bus_sel, r_en, a_en, g_en, add_sub, done};
  endfunction

  function automatic logic [OV_W-1:0] vec(input bit irl, input int sel, input int ren_idx,
                                          input bit a, input bit g, input bit as, input bit d);
    logic [NREG-1:0] ren;
    ren = '0;
    if (ren_idx >= 0) ren[ren_idx] = 1'b1;
    return {irl, SEL_W'(sel), ren, a, g, as, d};
  endfunction

  // Reference model: cycle count of an instruction from the accepting T0 cycle
  function automatic int model_len(input logic [IR_W-1:0] ins);
    int op;
    op = int'(ins[8:6]);
    return (op == 2 || op == 3) ? 4 : 2;
  endfunction

  // Reference model: expected outputs for cycle k of an instruction (k=0 is accept)
  function automatic logic [OV_W-1:0] model_step(input logic [IR_W-1:0] ins, input int k);
    int op, x, y;
    op = int'(ins[8:6]);
    x  = int'(ins[5:3]);
    y  = int'(ins[2:0]);
    if (k == 0) return vec(1, 0, -1, 0, 0, 0, 0);
    if (op == 2 || op == 3) begin
      if (k == 1) return vec(0, x, -1, 1, 0, 0, 0);
      if (k == 2) return vec(0, y, -1, 0, 1, op == 3, 0);
      return vec(0, NREG + 1, x, 0, 0, 0, 1);
    end
    if (op == 0) return vec(0, y, x, 0, 0, 0, 1);
    if (op == 1) return vec(0, NREG, x, 0, 0, 0, 1);
    return vec(0, 0, -1, 0, 0, 0, 1);
  endfunction

  // Driver: issues one instruction starting at posedge+1 with the FSM in T0,
  // records outputs of every cycle; run is randomized while it must be ignored.
  task automatic exec(input logic [IR_W-1:0] ins, output logic [3:0][OV_W-1:0] got,
                      output int n);
    n = model_len(ins);
    got = '0;
    ir_in = ins;
    run = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      got[k] = obs();
      @(posedge clk);
      #1;
      run   = (k == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      ir_in = IR_W'($urandom);
    end
  endtask

  task automatic idle_cycle(input string name);
    @(negedge clk);
    n_cmp++;
    if (obs() !== '0) begin
      n_bad++;
      $display("FAIL %s idle: got %h expected %h", name, obs(), {OV_W{1'b0}});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b1;
    ir_in = 9'b010_011_100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== '0) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: got %h expected %h", i, obs(), {OV_W{1'b0}});
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs() !== vec(1, 0, -1, 0, 0, 0, 0)) begin
      n_bad++;
      $display("FAIL reset_release: got %h expected %h", obs(), vec(1, 0, -1, 0, 0, 0, 0));
    end
    #1;
    run = 1'b0;
    @(posedge clk);
    #1;
    idle_cycle("reset_idle");
  endtask

  task automatic test_single(input string name, input logic [IR_W-1:0] ins);
    logic [3:0][OV_W-1:0] got;
    int n;
    exec(ins, got, n);
    for (int k = 0; k < n; k++) begin
      n_cmp++;
      if (got[k] !== model_step(ins, k)) begin
        n_bad++;
        $display("FAIL %s step%0d: got %h expected %h", name, k, got[k], model_step(ins, k));
      end
    end
    idle_cycle(name);
  endtask

  task automatic test_back_to_back();
    logic [3:0][OV_W-1:0] g1;
    logic [3:0][OV_W-1:0] g2;
    int n1, n2;
    logic [IR_W-1:0] i1, i2;
    i1 = 9'b010_000_011;
    i2 = 9'b000_100_000;
    exec(i1, g1, n1);
    exec(i2, g2, n2);
    for (int k = 0; k < n1; k++) begin
      n_cmp++;
      if (g1[k] !== model_step(i1, k)) begin
        n_bad++;
        $display("FAIL b2b_add step%0d: got %h expected %h", k, g1[k], model_step(i1, k));
      end
    end
    for (int k = 0; k < n2; k++) begin
      n_cmp++;
      if (g2[k] !== model_step(i2, k)) begin
        n_bad++;
        $display("FAIL b2b_mv step%0d: got %h expected %h", k, g2[k], model_step(i2, k));
      end
    end
    idle_cycle("b2b");
  endtask

  task automatic test_reset_mid();
    logic [IR_W-1:0] ins;
    ins = 9'b010_010_101;
    ir_in = ins;
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== model_step(ins, k)) begin
        n_bad++;
        $display("FAIL rstmid step%0d: got %h expected %h", k, obs(), model_step(ins, k));
      end
      if (k < 2) begin
        @(posedge clk);
        #1;
        run = 1'b0;
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== '0) begin
      n_bad++;
      $display("FAIL rstmid_async: got %h expected %h", obs(), {OV_W{1'b0}});
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) idle_cycle("rstmid_after");
    test_single("nop111", 9'b111_011_010);
  endtask

  task automatic test_random();
    logic [3:0][OV_W-1:0] got;
    int n;
    logic [IR_W-1:0] ins;
    for (int t = 0; t < 40; t++) begin
      ins = IR_W'($urandom);
      exec(ins, got, n);
      for (int k = 0; k < n; k++) begin
        n_cmp++;
        if (got[k] !== model_step(ins, k)) begin
          n_bad++;
          $display("FAIL rand%0d ins=%b step%0d: got %h expected %h", t, ins, k, got[k],
                   model_step(ins, k));
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < int'($urandom_range(1, 2)); i++) idle_cycle("rand_gap");
      end
    end
    idle_cycle("rand_end");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    run   = 1'b0;
    ir_in = '0;
    test_reset();
    test_single("mv_r2_r5", 9'b000_010_101);
    test_single("mvi_r7", 9'b001_111_000);
    test_single("sub_r1_r6", 9'b011_001_110);
    test_single("add_r3_r3", 9'b010_011_011);
    test_back_to_back();
    test_reset_mid();
    test_single("nop100", 9'b100_101_001);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
